// File: rtl/sync_fifo_fwft_if.sv
// Handshake and status bundle for sync_fifo_fwft.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface sync_fifo_fwft_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wdata, rd_en, clr_err,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en, clr_err,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with first-word-fall-through or registered-read output,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit FWFT       = 1'b1,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_fwft_if.slave    bus_io
);
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = ADDR_WIDTH + 1;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_fwft: FIFO_DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
      $error("sync_fifo_fwft: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_fwft: AE_LEVEL out of range");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("sync_fifo_fwft: DATA_WIDTH must be >= 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  // Requests are qualified with the pre-edge flags; rst masks both sides.
  assign wr_acc = bus_io.wr_en && !full  && !rst;
  assign rd_acc = bus_io.rd_en && !empty && !rst;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus_io.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      count_q <= count_d;
      // Set has priority over clear.
      if (bus_io.wr_en && full)        overflow_q  <= 1'b1;
      else if (bus_io.clr_err)         overflow_q  <= 1'b0;
      if (bus_io.rd_en && empty)       underflow_q <= 1'b1;
      else if (bus_io.clr_err)         underflow_q <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus_io.rdata  = mem_q[rd_ptr_q];
      assign bus_io.rvalid = !empty;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rvalid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
        end
      end

      assign bus_io.rdata  = rdata_q;
      assign bus_io.rvalid = rvalid_q;
    end
  endgenerate

  assign bus_io.full         = full;
  assign bus_io.empty        = empty;
  assign bus_io.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus_io.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign bus_io.count        = count_q;
  assign bus_io.overflow     = overflow_q;
  assign bus_io.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench: one FWFT FIFO and one registered-read FIFO, depth 16,
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_sync_fifo_fwft;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) fa ();
  sync_fifo_fwft_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) fb ();

  sync_fifo_fwft #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus_io(fa.slave)
  );
  sync_fifo_fwft #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus_io(fb.slave)
  );

  typedef struct {
    logic       rst, wr, rd, clr;
    logic [7:0] wdata;
    int         cnt;
    logic       emp, ful, ae, af, ovf, unf;
    logic       chk_data;
    logic [7:0] rdata;
    string      name;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    fa.wr_en = wr; fa.wdata = d; fa.rd_en = rd; fa.clr_err = clr;
  endtask

  task automatic drive_b(input logic wr, input logic [7:0] d, input logic rd);
    fb.wr_en = wr; fb.wdata = d; fb.rd_en = rd; fb.clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);

    //          rst  wr   rd   clr  wdata  cnt emp  ful  ae   af   ovf  unf  chk  rdata
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,"reset"};
    vecs[1] = '{1'b0,1'b1,1'b0,1'b0,8'hA1, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hA1,"wr_a1"};
    vecs[2] = '{1'b0,1'b1,1'b0,1'b0,8'hA2, 2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hA1,"wr_a2"};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b0,8'hA3, 3, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'hA1,"wr_a3"};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b0,8'h00, 2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hA2,"pop1"};
    vecs[5] = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'hA3,"pop2"};
    vecs[6] = '{1'b0,1'b0,1'b1,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,"pop3"};
    vecs[7] = '{1'b0,1'b1,1'b1,1'b0,8'h55, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h55,"wr_rd_empty"};
    vecs[8] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h55,"clr_unf"};
    vecs[9] = '{1'b0,1'b0,1'b1,1'b0,8'h00, 0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,"pop_55"};

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst;
      drive_a(vecs[i].wr, vecs[i].wdata, vecs[i].rd, vecs[i].clr);
      tick();
      chk({vecs[i].name, ".count"},  int'(fa.count),        vecs[i].cnt);
      chk({vecs[i].name, ".empty"},  int'(fa.empty),        int'(vecs[i].emp));
      chk({vecs[i].name, ".full"},   int'(fa.full),         int'(vecs[i].ful));
      chk({vecs[i].name, ".aempty"}, int'(fa.almost_empty), int'(vecs[i].ae));
      chk({vecs[i].name, ".afull"},  int'(fa.almost_full),  int'(vecs[i].af));
      chk({vecs[i].name, ".ovf"},    int'(fa.overflow),     int'(vecs[i].ovf));
      chk({vecs[i].name, ".unf"},    int'(fa.underflow),    int'(vecs[i].unf));
      chk({vecs[i].name, ".rvalid"}, int'(fa.rvalid),       int'(!vecs[i].emp));
      if (vecs[i].chk_data) chk({vecs[i].name, ".rdata"}, int'(fa.rdata), int'(vecs[i].rdata));
      $display("vec %0d %s: count=%0d rdata=0x%0h", i, vecs[i].name, fa.count, fa.rdata);
    end
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, then overflow attempt with 0xFF
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
      chk("fill.count", int'(fa.count), i + 1);
      chk("fill.afull", int'(fa.almost_full), int'(i + 1 >= 14));
      chk("fill.full",  int'(fa.full), int'(i == 15));
      chk("fill.head",  int'(fa.rdata), 0);
      $display("fill %0d: count=%0d", i, fa.count);
    end
    drive_a(1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("ovf.count", int'(fa.count), 16);
    chk("ovf.flag",  int'(fa.overflow), 1);
    $display("overflow write: count=%0d overflow=%0b", fa.count, fa.overflow);
    for (int i = 0; i < 16; i++) begin
      chk("drain.rdata", int'(fa.rdata), i);
      drive_a(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("drain.count", int'(fa.count), 15 - i);
      $display("drain %0d: count=%0d", i, fa.count);
    end
    chk("drain.empty", int'(fa.empty), 1);
    chk("drain.ovf_sticky", int'(fa.overflow), 1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("clr.ovf", int'(fa.overflow), 0);
    $display("clr_err: overflow=%0b", fa.overflow);

    // Full FIFO with simultaneous read and write: read wins
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      tick();
    end
    chk("full2.full", int'(fa.full), 1);
    drive_a(1'b1, 8'hEE, 1'b1, 1'b0);
    tick();
    chk("full_rw.count", int'(fa.count), 15);
    chk("full_rw.ovf",   int'(fa.overflow), 1);
    chk("full_rw.head",  int'(fa.rdata), 8'h31);
    $display("full rd+wr: count=%0d head=0x%0h", fa.count, fa.rdata);
    for (int i = 1; i < 16; i++) begin
      chk("full_rw.drain", int'(fa.rdata), 8'h30 + i);
      drive_a(1'b0, 8'h00, 1'b1, 1'b1);
      tick();
    end
    chk("full_rw.empty", int'(fa.empty), 1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);

    // Registered-read variant
    drive_b(1'b1, 8'h11, 1'b0); tick();
    drive_b(1'b1, 8'h22, 1'b0); tick();
    drive_b(1'b0, 8'h00, 1'b0);
    chk("b.count2", int'(fb.count), 2);
    chk("b.rvalid_idle", int'(fb.rvalid), 0);
    chk("b.rdata_reset", int'(fb.rdata), 0);
    drive_b(1'b0, 8'h00, 1'b1); tick();
    drive_b(1'b0, 8'h00, 1'b0);
    chk("b.rd1.rdata", int'(fb.rdata), 8'h11);
    chk("b.rd1.rvalid", int'(fb.rvalid), 1);
    chk("b.rd1.count", int'(fb.count), 1);
    $display("b read1: rdata=0x%0h rvalid=%0b", fb.rdata, fb.rvalid);
    tick();
    chk("b.hold.rvalid", int'(fb.rvalid), 0);
    chk("b.hold.rdata", int'(fb.rdata), 8'h11);
    drive_b(1'b0, 8'h00, 1'b1); tick();
    chk("b.rd2.rdata", int'(fb.rdata), 8'h22);
    chk("b.rd2.rvalid", int'(fb.rvalid), 1);
    chk("b.rd2.empty", int'(fb.empty), 1);
    tick();
    drive_b(1'b0, 8'h00, 1'b0);
    chk("b.unf.rvalid", int'(fb.rvalid), 0);
    chk("b.unf.rdata", int'(fb.rdata), 8'h22);
    chk("b.unf.flag", int'(fb.underflow), 1);
    $display("b read on empty: rvalid=%0b underflow=%0b", fb.rvalid, fb.underflow);

    // Wrap-around: 40 write/read pairs streaming at occupancy 1
    drive_a(1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 40; i++) begin
      chk("wrap.head", int'(fa.rdata), i - 1);
      drive_a(1'b1, 8'(i), 1'b1, 1'b0);
      tick();
      chk("wrap.count", int'(fa.count), 1);
    end
    $display("wrap: 40 pairs streamed, head=0x%0h", fa.rdata);
    chk("wrap.last", int'(fa.rdata), 40);
    drive_a(1'b0, 8'h00, 1'b1, 1'b0);
    tick();

    // Mid-operation reset with flags set and count=5
    drive_a(1'b0, 8'h00, 1'b1, 1'b0); tick();
    chk("pre_rst.unf", int'(fa.underflow), 1);
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      tick();
    end
    chk("pre_rst.count", int'(fa.count), 5);
    rst = 1'b1;
    drive_a(1'b1, 8'h99, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst.count",  int'(fa.count), 0);
    chk("rst.empty",  int'(fa.empty), 1);
    chk("rst.ovf",    int'(fa.overflow), 0);
    chk("rst.unf",    int'(fa.underflow), 0);
    chk("rst.rvalid", int'(fa.rvalid), 0);
    $display("mid reset: count=%0d empty=%0b", fa.count, fa.empty);
    tick();
    chk("post_rst.count", int'(fa.count), 0);
    chk("post_rst.empty", int'(fa.empty), 1);
    drive_a(1'b1, 8'hC0, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst.wr.count", int'(fa.count), 1);
    chk("post_rst.wr.rdata", int'(fa.rdata), 8'hC0);
    $display("post reset write: count=%0d rdata=0x%0h", fa.count, fa.rdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Parametrised single-clock FIFO. It is the successor to the team's basic synchronous FIFO. Adds:
- selectable first-word-fall-through (FWFT) or registered-read mode
- occupancy count output
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow error flags

Used as the standard buffering element between streaming stages in one clock domain.

Parameters:
DATA_WIDTH, 8, word width in bits (>=1)
FIFO_DEPTH, 16, number of entries; power of two, >=2
FWFT, 1, 1 = head word visible on rdata without a read; 0 = registered read, 1-cycle latency
AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..FIFO_DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..FIFO_DEPTH-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
wdata  in  DATA_WIDTH  write data
rd_en  in  1  read request (FWFT: pop/acknowledge head)
rdata  out  DATA_WIDTH  read data
rvalid  out  1  rdata holds a valid word (see Behaviour)
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- ADDR_WIDTH = $clog2(FIFO_DEPTH). The wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap naturally from FIFO_DEPTH-1 to 0.
- Write accepted (wr_acc) iff wr_en && !full, using the pre-edge full. Read accepted (rd_acc) iff rd_en && !empty, using the pre-edge empty.
- On wr_acc: mem[wr_ptr] <= wdata, and wr_ptr increments. On rd_acc: rd_ptr increments.
- count increments on wr_acc only, decrements on rd_acc only, and is unchanged when both or neither occur. Rejected requests never change count.
- Full with wr_en and rd_en in the same cycle: the read is accepted and the write is rejected. overflow sets and count becomes FIFO_DEPTH-1.
- Empty with wr_en and rd_en in the same cycle: the write is accepted and the read is rejected. underflow sets and count becomes 1. There is no write-to-read bypass.
- FWFT=1:
  - rdata = mem[rd_ptr], combinational from the pointer; rvalid = !empty.
  - A word written at edge N appears on rdata with empty=0 after edge N.
  - rdata is don't-care while empty.
- FWFT=0:
  - On rd_acc, rdata <= mem[rd_ptr] at that edge, and rvalid pulses high for exactly the following cycle.
  - rdata holds its last value otherwise.
- Flags full, empty, almost_full and almost_empty are combinational from count, so they are valid the cycle after the causing edge.
- overflow sets on wr_en && full; underflow sets on rd_en && empty. Both hold until clr_err. If set and clear occur in the same cycle, set wins.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, rdata=0, rvalid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=0.
- Reset mid-operation:
  - All pointers and flags return to reset values at that edge.
  - wr_en and rd_en are ignored in any cycle where rst=1.
  - Memory contents are not cleared and are never exposed as valid.
- Parameter check: elaboration fails if FIFO_DEPTH is not a power of two or a threshold is out of range.

Test Plan:
1. FWFT=1, DEPTH=16. After reset, write 0xA1, 0xA2, 0xA3 on consecutive cycles -> after the first edge rdata=0xA1, rvalid=1, count=1. Pop three times -> rdata shows 0xA2, then 0xA3; then empty=1, count=0.
2. Fill 16 words 0x00..0x0F -> full=1 and almost_full=1 from count 14. A 17th write with value 0xFF is dropped and overflow=1. Drain -> data reads 0x00..0x0F in order with no 0xFF. Pulse clr_err -> overflow=0.
3. Empty FIFO, rd_en and wr_en together with wdata=0x55 -> underflow=1, count=1. Next cycle rdata=0x55 (FWFT).
4. Full FIFO, simultaneous rd_en and wr_en -> head popped, write dropped, count=15, overflow=1.
5. FWFT=0. Write 0x11 and 0x22, then assert rd_en for one cycle -> the cycle after the edge shows rdata=0x11 and rvalid=1. The next cycle shows rvalid=0 and rdata still 0x11.
6. Wrap-around and reset:
   - Run 40 write/read pairs with incrementing data through DEPTH=16 -> the output sequence matches the input exactly.
   - Assert rst with count=5 -> count=0, empty=1, overflow=0 next cycle.
   - A write issued during the rst cycle is not stored.
